// File: rtl/karatsuba_mul_param_if.sv
// Request/result bundle for the iterative Karatsuba multiplier.
// The requester holds the master side: it drives start, x and y and observes
// product, done and busy.
interface karatsuba_mul_param_if #(
  parameter int WIDTH = 16
) ();

  logic                 start;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic [2*WIDTH-1:0]   product;
  logic                 done;
  logic                 busy;

  modport master (
    output start, x, y,
    input  product, done, busy
  );

  modport slave (
    input  start, x, y,
    output product, done, busy
  );

endinterface

// File: rtl/karatsuba_mul_param.sv
// Iterative WIDTH x WIDTH Karatsuba multiplier.
// Three H-bit Karatsuba sub-products (lo*lo, hi*hi, (lo+hi)*(lo+hi)) run in
// parallel as bit-serial shift-and-add engines for H+1 cycles, then the middle
// term is formed and the halves are recombined. The latency is fixed at H+4
// clocks from the accepting edge to done.
// Optional build macro KARATSUBA_SIGNED_EN: operands are two's complement. The
// engines work on magnitudes and the product is negated at the end when the
// operand signs differ. Without the macro, operands are unsigned and no sign
// logic exists.
module karatsuba_mul_param #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  karatsuba_mul_param_if.slave  bus
);

  localparam int H  = WIDTH / 2;
  localparam int EW = 2 * H + 2;        // engine accumulator width
  localparam int PW = 2 * WIDTH;        // product width
  localparam int CW = $clog2(H + 1);    // iteration counter width

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    COMBINE,
    FINISH
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  x_q;
  logic [WIDTH-1:0]  y_q;
  logic [CW-1:0]     cnt;
  logic [EW-1:0]     acc    [3];        // 0: z0, 1: z2, 2: w
  logic [EW-1:0]     mcand  [3];
  logic [H:0]        mplier [3];
  logic [EW-1:0]     z1;
  logic [PW-1:0]     product_q;
  logic              done_q;
`ifdef KARATSUBA_SIGNED_EN
  logic              sign_q;
`endif

  // Operand magnitudes: pass-through for unsigned, absolute value for signed.
  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  logic [WIDTH-1:0]  x_mag;
  logic [WIDTH-1:0]  y_mag;
`ifdef KARATSUBA_SIGNED_EN
  assign x_mag = x_q[WIDTH-1] ? (~x_q + WIDTH'(1)) : x_q;
  assign y_mag = y_q[WIDTH-1] ? (~y_q + WIDTH'(1)) : y_q;
`else
  assign x_mag = x_q;
  assign y_mag = y_q;
`endif

  logic [H-1:0]      x_lo, x_hi, y_lo, y_hi;
  logic [H:0]        x_sum, y_sum;
  assign x_lo  = x_mag[H-1:0];
  assign x_hi  = x_mag[WIDTH-1:H];
  assign y_lo  = y_mag[H-1:0];
  assign y_hi  = y_mag[WIDTH-1:H];
  assign x_sum = {1'b0, x_lo} + {1'b0, x_hi};
  assign y_sum = {1'b0, y_lo} + {1'b0, y_hi};

  // Recombine the three terms. The true product fits in PW bits, so modular
  // PW-bit arithmetic gives the same result as the wider sum truncated.
  logic [PW-1:0]     assembled;
  always_comb begin
    assembled = (PW'(acc[1][2*H-1:0]) << WIDTH)
              + (PW'(z1) << H)
              +  PW'(acc[0][2*H-1:0]);
  end

  // Control FSM and datapath registers, all advanced on the same edge.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain the engine updates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      cnt       <= '0;
      z1        <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
`ifdef KARATSUBA_SIGNED_EN
      sign_q    <= 1'b0;
`endif
      // NOTE: the engine arrays are a handful of flops, not a RAM, so they are
      // reset like any other register and never start from stale contents.
      for (int i = 0; i < 3; i++) begin
        acc[i]    <= '0;
        mcand[i]  <= '0;
        mplier[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            x_q   <= bus.x;
            y_q   <= bus.y;
            state <= LOAD;
          end
        end

        LOAD: begin
`ifdef KARATSUBA_SIGNED_EN
          sign_q    <= x_q[WIDTH-1] ^ y_q[WIDTH-1];
`endif
          mcand[0]  <= EW'(x_lo);
          mplier[0] <= {1'b0, y_lo};
          mcand[1]  <= EW'(x_hi);
          mplier[1] <= {1'b0, y_hi};
          mcand[2]  <= EW'(x_sum);
          mplier[2] <= y_sum;
          for (int i = 0; i < 3; i++) acc[i] <= '0;
          cnt       <= '0;
          state     <= MUL;
        end

        MUL: begin
          for (int i = 0; i < 3; i++) begin
            if (mplier[i][0]) acc[i] <= acc[i] + mcand[i];
            mcand[i]  <= mcand[i] << 1;
            mplier[i] <= mplier[i] >> 1;
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(H)) state <= COMBINE;
        end

        COMBINE: begin
          // w >= z0 + z2 always, so the middle term never goes negative.
          z1    <= acc[2] - acc[0] - acc[1];
          state <= FINISH;
        end

        FINISH: begin
`ifdef KARATSUBA_SIGNED_EN
          product_q <= sign_q ? (~assembled + PW'(1)) : assembled;
`else
          product_q <= assembled;
`endif
          done_q    <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_karatsuba_mul_param.sv
// Directed bench for karatsuba_mul_param: a WIDTH=16 instance for reset,
// latency, corners, handshake and mid-operation reset, and a WIDTH=8 instance
// swept against a plain multiply. Build with KARATSUBA_SIGNED_EN to check the
// two's-complement variant; expectations switch with the same macro.
module tb_karatsuba_mul_param;

  logic clk;
  logic reset_n;

  int n_checks = 0;
  int n_fail   = 0;

  karatsuba_mul_param_if #(.WIDTH(16)) bus16 ();
  karatsuba_mul_param_if #(.WIDTH(8))  bus8 ();

  karatsuba_mul_param #(.WIDTH(16)) u_dut16 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus16)
  );

  karatsuba_mul_param #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=16 transaction, called at a falling edge with the DUT idle.
  // Operands are scrambled right after acceptance. lat counts clocks from the
  // accepting edge to the edge that raised done (-1 on timeout).
  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] p, output int lat,
                       output int busy_n, output logic done_after);
    bus16.start = 1'b1;
    bus16.x     = a;
    bus16.y     = b;
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    bus16.x     = ~a;
    bus16.y     = ~b;
    lat    = -1;
    busy_n = 0;
    p      = '0;
    for (int m = 0; m < 40; m++) begin
      if (bus16.done) begin
        lat = m;
        p   = bus16.product;
        break;
      end
      if (bus16.busy) busy_n++;
      @(negedge clk);
    end
    @(negedge clk);
    done_after = bus16.done;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] p, output int lat);
    bus8.start = 1'b1;
    bus8.x     = a;
    bus8.y     = b;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.x     = ~a;
    lat = -1;
    p   = '0;
    for (int m = 0; m < 30; m++) begin
      if (bus8.done) begin
        lat = m;
        p   = bus8.product;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // Reference for the 8-bit instance: extend to 16 bits per signedness; the
  // low 16 bits of that product are the expected result.
  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ea, eb;
`ifdef KARATSUBA_SIGNED_EN
    ea = {{8{a[7]}}, a};
    eb = {{8{b[7]}}, b};
`else
    ea = {8'h00, a};
    eb = {8'h00, b};
`endif
    return ea * eb;
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    string       tag;
  } vec16_t;

  initial begin
    logic [31:0] p;
    logic [15:0] p8;
    int          lat, busy_n, dones, prev_m;
    logic        done_after;
    vec16_t      vecs [7];

    vecs[0] = '{16'h012C, 16'h00C8, 32'h0000EA60, "300x200"};
    vecs[1] = '{16'h0000, 16'hFFFF, 32'h00000000, "0xFFFF"};
    vecs[2] = '{16'h00FF, 16'h00FF, 32'h0000FE01, "FFxFF_midcarry"};
`ifdef KARATSUBA_SIGNED_EN
    vecs[3] = '{16'hFFFF, 16'hFFFF, 32'h00000001, "FFFFxFFFF"};
    vecs[4] = '{16'hFFFF, 16'h0002, 32'hFFFFFFFE, "m1x2"};
    vecs[5] = '{16'h8000, 16'h8000, 32'h40000000, "minxmin"};
    vecs[6] = '{16'h8000, 16'h0001, 32'hFFFF8000, "minx1"};
`else
    vecs[3] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, "FFFFxFFFF"};
    vecs[4] = '{16'hFFFF, 16'h0002, 32'h0001FFFE, "m1x2"};
    vecs[5] = '{16'h8000, 16'h8000, 32'h40000000, "minxmin"};
    vecs[6] = '{16'h8000, 16'h0001, 32'h00008000, "minx1"};
`endif

    bus16.start = 1'b0; bus16.x = '0; bus16.y = '0;
    bus8.start  = 1'b0; bus8.x  = '0; bus8.y  = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_product", 64'(bus16.product), 64'h0);
    check("rst_done",    64'(bus16.done),    64'h0);
    check("rst_busy",    64'(bus16.busy),    64'h0);
    check("rst_product8", 64'(bus8.product), 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // First vector also carries the timing checks.
    run16(vecs[0].a, vecs[0].b, p, lat, busy_n, done_after);
    check("first_product", 64'(p), 64'(vecs[0].exp));
    check("latency16", 64'(lat), 64'd12);
    check("busy_cycles", 64'(busy_n), 64'd12);
    check("done_one_cycle", 64'(done_after), 64'h0);
    check("product_held", 64'(bus16.product), 64'(vecs[0].exp));

    for (int i = 1; i < 7; i++) begin
      run16(vecs[i].a, vecs[i].b, p, lat, busy_n, done_after);
      check(vecs[i].tag, 64'(p), 64'(vecs[i].exp));
      check({vecs[i].tag, "_lat"}, 64'(lat), 64'd12);
    end

    // A start pulse while busy must be ignored entirely.
    bus16.start = 1'b1; bus16.x = 16'h0101; bus16.y = 16'h0202;
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    dones = 0; p = '0;
    for (int m = 0; m < 40; m++) begin
      if (m == 5) begin
        bus16.start = 1'b1; bus16.x = 16'h7777; bus16.y = 16'h7777;
      end
      if (m == 6) bus16.start = 1'b0;
      if (bus16.done) begin
        dones++;
        p = bus16.product;
      end
      @(negedge clk);
    end
    check("busy_start_dones", 64'(dones), 64'd1);
    check("busy_start_product", 64'(p), 64'h00020402);

    // start held high: one result every 13 clocks.
    bus16.start = 1'b1; bus16.x = 16'h1234; bus16.y = 16'h0056;
    @(posedge clk);
    @(negedge clk);
    dones = 0; prev_m = -1;
    for (int m = 0; m < 45; m++) begin
      if (bus16.done) begin
        dones++;
        check("b2b_product", 64'(bus16.product), 64'h00061D78);
        if (prev_m >= 0) check("b2b_spacing", 64'(m - prev_m), 64'd13);
        else             check("b2b_first_lat", 64'(m), 64'd12);
        prev_m = m;
      end
      @(negedge clk);
    end
    bus16.start = 1'b0;
    check("b2b_dones", 64'(dones), 64'd3);
    repeat (20) @(negedge clk);

    // Reset in the middle of an operation discards it.
    bus16.start = 1'b1; bus16.x = 16'd7; bus16.y = 16'd9;
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_product", 64'(bus16.product), 64'h0);
    check("midrst_done",    64'(bus16.done),    64'h0);
    check("midrst_busy",    64'(bus16.busy),    64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    for (int m = 0; m < 20; m++) begin
      if (bus16.done) dones++;
      @(negedge clk);
    end
    check("midrst_no_done", 64'(dones), 64'd0);
    run16(16'd3, 16'd5, p, lat, busy_n, done_after);
    check("after_rst_3x5", 64'(p), 64'd15);
    check("after_rst_lat", 64'(lat), 64'd12);

    // WIDTH=8 instance: corners, latency, then a random sweep.
    run8(8'hFF, 8'hFF, p8, lat);
    check("w8_FFxFF", 64'(p8), 64'(ref8(8'hFF, 8'hFF)));
    check("w8_latency", 64'(lat), 64'd8);
    run8(8'h80, 8'h80, p8, lat);
    check("w8_80x80", 64'(p8), 64'h4000);
    run8(8'h80, 8'h01, p8, lat);
`ifdef KARATSUBA_SIGNED_EN
    check("w8_80x01", 64'(p8), 64'hFF80);
`else
    check("w8_80x01", 64'(p8), 64'h0080);
`endif
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      run8(a, b, p8, lat);
      check("w8_random", 64'(p8), 64'(ref8(a, b)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
